// File: rtl/int_div_wb_merge_if.sv
// Signal bundle between the divider/EXE/regfile side and the divide-result writeback merger.
interface int_div_wb_merge_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             div_valid;
  logic             div_we;
  logic [4:0]       div_rd;
  logic [WIDTH-1:0] div_result;
  logic             div_en;
  logic             exe_valid;
  logic             exe_we;
  logic [4:0]       exe_rd;
  logic [WIDTH-1:0] exe_result;
  logic             exe_stall;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_hit;
  logic             rs2_hit;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             err_ovf;

  modport slave (
    input  flush, div_valid, div_we, div_rd, div_result,
    input  exe_valid, exe_we, exe_rd, exe_result, rs1_addr, rs2_addr,
    output div_en, exe_stall, wb_valid, wb_rd, wb_data,
    output rs1_hit, rs2_hit, rs1_data, rs2_data, err_ovf
  );

  modport master (
    output flush, div_valid, div_we, div_rd, div_result,
    output exe_valid, exe_we, exe_rd, exe_result, rs1_addr, rs2_addr,
    input  div_en, exe_stall, wb_valid, wb_rd, wb_data,
    input  rs1_hit, rs2_hit, rs1_data, rs2_data, err_ovf
  );
endinterface

// File: rtl/int_div_wb_merge.sv
// Buffers divider results in order and merges them with the EXE stream onto the single
// register-file writeback port, with starvation relief and operand forwarding.
module int_div_wb_merge #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  int_div_wb_merge_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       mem_rd_q   [DEPTH];
  logic [WIDTH-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [SW-1:0]    starve_q;
  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             err_ovf_q;

  logic full, push_req, push_ok, exe_req, buf_req, starve, pop, exe_win;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    push_req = bus.div_valid && bus.div_we && (bus.div_rd != 5'd0);
    push_ok  = push_req && !full;
    exe_req  = bus.exe_valid && bus.exe_we && (bus.exe_rd != 5'd0);
    buf_req  = (count_q != '0);
    starve   = buf_req && (starve_q == SW'(STARVE_LIMIT));
    pop      = buf_req && (starve || !exe_req);
    exe_win  = exe_req && !starve;
  end

  assign bus.div_en    = !full;
  assign bus.exe_stall = starve;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err_ovf   = err_ovf_q;

  // Scan oldest to youngest so the youngest matching entry overrides older ones.
  function automatic logic [WIDTH:0] lookup(input logic [4:0] addr);
    logic [WIDTH:0] res;
    logic [PW-1:0]  idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr != 5'd0) && (mem_rd_q[idx] == addr)) begin
        res = {1'b1, mem_data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {bus.rs1_hit, bus.rs1_data} = lookup(bus.rs1_addr);
    {bus.rs2_hit, bus.rs2_data} = lookup(bus.rs2_addr);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) begin
      mem_rd_q[wr_ptr_q]   <= bus.div_rd;
      mem_data_q[wr_ptr_q] <= bus.div_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      if (push_req && full) begin
        err_ovf_q <= 1'b1;
      end
      if (bus.flush) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        starve_q   <= '0;
        wb_valid_q <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (pop && !push_ok) begin
          count_q <= count_q - 1'b1;
        end

        if (pop || !buf_req) begin
          starve_q <= '0;
        end else if (exe_win && (starve_q != SW'(STARVE_LIMIT))) begin
          starve_q <= starve_q + 1'b1;
        end

        // With no winner the data/rd registers keep their last value.
        if (pop) begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= mem_rd_q[rd_ptr_q];
          wb_data_q  <= mem_data_q[rd_ptr_q];
        end else if (exe_win) begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= bus.exe_rd;
          wb_data_q  <= bus.exe_result;
        end else begin
          wb_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_div_wb_merge.sv
// Directed self-checking bench for int_div_wb_merge (WIDTH=32, DEPTH=2, STARVE_LIMIT=4).
module tb_int_div_wb_merge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int_div_wb_merge_if #(.WIDTH(32)) bus ();

  int_div_wb_merge #(
    .WIDTH       (32),
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; registered outputs are settled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic div_push(input logic [4:0] rd, input logic [31:0] res);
    bus.div_valid  = 1'b1;
    bus.div_we     = 1'b1;
    bus.div_rd     = rd;
    bus.div_result = res;
  endtask

  task automatic div_idle();
    bus.div_valid  = 1'b0;
    bus.div_we     = 1'b0;
    bus.div_rd     = 5'd0;
    bus.div_result = '0;
  endtask

  task automatic exe_drive(input logic v, input logic [4:0] rd, input logic [31:0] res);
    bus.exe_valid  = v;
    bus.exe_we     = v;
    bus.exe_rd     = rd;
    bus.exe_result = res;
  endtask

  initial begin
    bus.flush    = 1'b0;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    div_idle();
    exe_drive(1'b0, 5'd0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check_eq("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check_eq("rst_exe_stall", 64'(bus.exe_stall), 64'd0);
    check_eq("rst_err_ovf", 64'(bus.err_ovf), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("rst_div_en", 64'(bus.div_en), 64'd1);

    // Single completion, exe idle: writeback two cycles later
    div_push(5'd5, 32'h0000_0007);
    tick();
    div_idle();
    check_eq("single_wb_early", 64'(bus.wb_valid), 64'd0);
    check_eq("single_div_en", 64'(bus.div_en), 64'd1);
    tick();
    check_eq("single_wb_valid", 64'(bus.wb_valid), 64'd1);
    check_eq("single_wb_rd", 64'(bus.wb_rd), 64'd5);
    check_eq("single_wb_data", 64'(bus.wb_data), 64'h7);
    tick();
    check_eq("single_wb_done", 64'(bus.wb_valid), 64'd0);
    check_eq("single_wb_rd_hold", 64'(bus.wb_rd), 64'd5);

    // Back-to-back completions against a continuous EXE stream
    exe_drive(1'b1, 5'd9, 32'h0000_0099);
    div_push(5'd3, 32'h0000_0033);
    tick();
    check_eq("b2b_exe_first", 64'(bus.wb_rd), 64'd9);
    div_push(5'd4, 32'h0000_0044);
    tick();
    div_idle();
    check_eq("b2b_div_en_full", 64'(bus.div_en), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check_eq("b2b_no_stall", 64'(bus.exe_stall), 64'd0);
      check_eq("b2b_exe_wins", 64'(bus.wb_rd), 64'd9);
      tick();
    end
    check_eq("b2b_stall", 64'(bus.exe_stall), 64'd1);
    check_eq("b2b_div_en_still0", 64'(bus.div_en), 64'd0);
    tick();
    check_eq("b2b_rd3", 64'(bus.wb_rd), 64'd3);
    check_eq("b2b_rd3_data", 64'(bus.wb_data), 64'h33);
    check_eq("b2b_div_en_back", 64'(bus.div_en), 64'd1);
    check_eq("b2b_stall_off", 64'(bus.exe_stall), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("b2b_exe_again", 64'(bus.wb_rd), 64'd9);
    end
    check_eq("b2b_stall2", 64'(bus.exe_stall), 64'd1);
    tick();
    check_eq("b2b_rd4", 64'(bus.wb_rd), 64'd4);
    check_eq("b2b_rd4_data", 64'(bus.wb_data), 64'h44);
    exe_drive(1'b0, 5'd0, '0);
    tick();
    check_eq("b2b_idle", 64'(bus.wb_valid), 64'd0);

    // Discarded completion (rd==0) produces no writeback
    div_push(5'd0, 32'h1234_5678);
    tick();
    div_idle();
    tick();
    check_eq("rd0_discard", 64'(bus.wb_valid), 64'd0);

    // Simultaneous push and pop at count=1
    div_push(5'd10, 32'h0000_00AA);
    tick();
    div_push(5'd11, 32'h0000_00BB);
    tick();
    div_idle();
    check_eq("pp_wb_rd10", 64'(bus.wb_rd), 64'd10);
    check_eq("pp_wb_data10", 64'(bus.wb_data), 64'hAA);
    check_eq("pp_div_en", 64'(bus.div_en), 64'd1);
    check_eq("pp_no_ovf", 64'(bus.err_ovf), 64'd0);
    tick();
    check_eq("pp_wb_rd11", 64'(bus.wb_rd), 64'd11);
    check_eq("pp_wb_data11", 64'(bus.wb_data), 64'hBB);
    tick();
    check_eq("pp_empty", 64'(bus.wb_valid), 64'd0);

    // Forwarding: youngest of two rd=7 entries wins; address 0 never hits
    exe_drive(1'b1, 5'd9, 32'h0000_0099);
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd0;
    div_push(5'd7, 32'hAAAA_0001);
    tick();
    check_eq("fwd_old_data", 64'(bus.rs1_data), 64'hAAAA_0001);
    div_push(5'd7, 32'hBBBB_0002);
    tick();
    div_idle();
    check_eq("fwd_hit", 64'(bus.rs1_hit), 64'd1);
    check_eq("fwd_young_data", 64'(bus.rs1_data), 64'hBBBB_0002);
    check_eq("fwd_zero_miss", 64'(bus.rs2_hit), 64'd0);

    // Push while full: ignored and flagged
    div_push(5'd13, 32'h0000_DEAD);
    tick();
    div_idle();
    check_eq("ovf_set", 64'(bus.err_ovf), 64'd1);
    check_eq("ovf_div_en", 64'(bus.div_en), 64'd0);
    check_eq("ovf_exe_wb", 64'(bus.wb_rd), 64'd9);

    // Flush with count=2 and a completion in the same cycle
    bus.flush = 1'b1;
    div_push(5'd12, 32'h0000_1212);
    tick();
    bus.flush = 1'b0;
    div_idle();
    exe_drive(1'b0, 5'd0, '0);
    check_eq("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("flush_div_en", 64'(bus.div_en), 64'd1);
    check_eq("flush_ovf_kept", 64'(bus.err_ovf), 64'd1);
    check_eq("flush_fwd_miss", 64'(bus.rs1_hit), 64'd0);
    tick();
    check_eq("flush_no_wb1", 64'(bus.wb_valid), 64'd0);
    tick();
    check_eq("flush_no_wb2", 64'(bus.wb_valid), 64'd0);

    // Asynchronous reset mid-operation drops buffered data and clears err_ovf
    div_push(5'd7, 32'h0000_0777);
    tick();
    div_idle();
    check_eq("mid_fwd_hit", 64'(bus.rs1_hit), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("arst_ovf_clr", 64'(bus.err_ovf), 64'd0);
    check_eq("arst_fwd_miss", 64'(bus.rs1_hit), 64'd0);
    check_eq("arst_wb_rd", 64'(bus.wb_rd), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("arst_no_wb", 64'(bus.wb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
